csi2_vc_framer: RTL and testbench
=================================

CSI2_VC_FRAMER -- requirements
Module: csi2_vc_framer

Interface
REQ-001 SHALL have parameter VC_EN, default 4'b1111: virtual-channel enable mask, bit n enables VC n.
REQ-002 SHALL have parameter LINE_CNT_WIDTH, default 12: width of each per-VC line counter.
REQ-003 SHALL have parameter EMBEDDED_PASS, default 0: 1 forwards data type 0x12 (embedded data) as well as pixel data.
REQ-004 clk_i  in  1  single clock for all logic; reset is synchronous and active-high.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 short_pkt_valid_i / short_pkt_v_channel_i / short_pkt_data_type_i / short_pkt_data_field_i  in  1/2/6/16  decoded short packet.
REQ-007 long_pkt_header_valid_i / long_pkt_v_channel_i / long_pkt_data_type_i / long_pkt_word_cnt_i  in  1/2/6/16  long packet header.
REQ-008 long_pkt_payload_i / long_pkt_payload_valid_i / long_pkt_payload_be_i / long_pkt_eop_i  in  32/1/4/1  payload beats.
REQ-009 crc_passed_i / crc_failed_i  in  1/1  CRC result pulse of the last long packet.
REQ-010 m_tdata_o / m_tvalid_o / m_tkeep_o / m_tuser_o / m_tlast_o / m_tdest_o  out  32/1/4/1/1/2  video stream; tuser = start of frame, tlast = end of line, tdest = VC.
REQ-011 frame_done_o / frame_done_vc_o / frame_lines_o  out  1/2/LINE_CNT_WIDTH  frame-end report pulse.
REQ-012 sync_err_o / sync_err_vc_o  out  1/2  framing-violation pulse.
REQ-013 crc_err_o / crc_err_vc_o  out  1/2  CRC-failure pulse for a forwarded packet.

Function
REQ-014 SHALL keep one FSM per enabled VC with states WAIT_FS and IN_FRAME, plus a per-VC sof_pending flag and line counter.
REQ-015 Short packet DT 0x00 (FS) on VC in WAIT_FS SHALL go to IN_FRAME, set sof_pending and clear the line counter.
REQ-016 FS on VC already in IN_FRAME SHALL pulse sync_err_o with that VC and restart the frame as in REQ-015, with no frame_done_o.
REQ-017 Short packet DT 0x01 (FE) in IN_FRAME SHALL pulse frame_done_o with frame_done_vc_o and frame_lines_o equal to the line counter, then go to WAIT_FS.
REQ-018 FE in WAIT_FS SHALL pulse sync_err_o and leave state unchanged.
REQ-019 Short packets with DT other than 0x00/0x01 SHALL be ignored.
REQ-020 Long header with DT 0x18-0x3F, or DT 0x12 when EMBEDDED_PASS=1, on a VC in IN_FRAME SHALL arm forwarding and latch the VC; all other long packets SHALL be dropped.
REQ-021 A forwardable long header on a VC in WAIT_FS SHALL pulse sync_err_o and drop the packet.
REQ-022 Each payload beat while armed SHALL appear on the stream 1 cycle later: tdata = payload, tkeep = be, tdest = latched VC, tvalid = 1.
REQ-023 tuser SHALL be 1 on the first forwarded beat after FS and clear sof_pending.
REQ-024 tlast SHALL equal long_pkt_eop_i; the eop beat SHALL disarm forwarding and increment the line counter, saturating at all-ones.
REQ-025 The stream has no backpressure; all outputs not driven by REQ-022 SHALL be 0 while tvalid = 0.
REQ-026 crc_failed_i after a forwarded packet SHALL pulse crc_err_o 1 cycle later with the latched VC; after a dropped packet it SHALL be ignored, and crc_passed_i SHALL have no effect.
REQ-027 All packets on VCs with VC_EN bit 0 SHALL be ignored, producing no errors and no stream beats.
REQ-028 When a short packet and a long header are valid in the same cycle, the short packet SHALL update VC state first and the header SHALL be evaluated against the updated state.
REQ-029 All report pulses (frame_done_o, sync_err_o, crc_err_o) SHALL be registered, 1 cycle wide, with latency 1 from the causing input.
REQ-030 When sync_err_o and frame_done_o are caused in the same cycle, both SHALL pulse.

Reset
REQ-031 rst_i SHALL force every FSM to WAIT_FS, clear sof_pending, line counters and the armed flag, and drive every output to 0 on the next edge.
REQ-032 Payload beats arriving after a mid-packet reset SHALL be dropped until the next forwardable header in IN_FRAME.

Verification
REQ-033 FS vc0, 3 lines x 4 beats DT 0x2B, FE -> 12 beats with tuser on beat 1 only, tlast on beats 4/8/12, tdest 0, then frame_done_o with frame_lines_o = 3.
REQ-034 Interleaved FS vc1, FS vc2, line vc2, line vc1, FE vc1, FE vc2 -> each VC sees tuser on its first beat, then frame_done for vc1 with 1 line, then for vc2 with 1 line.
REQ-035 Long DT 0x2B on vc3 before FS -> sync_err_o with vc 3 and no stream beats; FE in WAIT_FS -> sync_err_o.
REQ-036 VC_EN=4'b0001 with FS/line/FE on vc2 -> no outputs at all; EMBEDDED_PASS=0 with DT 0x12 -> dropped, no error.
REQ-037 crc_failed_i after a forwarded vc1 line -> crc_err_o with vc 1; rst_i asserted mid-line -> outputs 0, remaining beats dropped, FE afterwards -> sync_err_o.
REQ-038 LINE_CNT_WIDTH=2 with 5 lines -> frame_lines_o = 3 (saturated).

Source files
------------

// File: rtl/csi2_vc_framer.sv
// csi2_vc_framer: tracks CSI-2 frames per virtual channel and forwards pixel payload as a video stream
module csi2_vc_framer #(
   parameter logic [3:0] VC_EN          = 4'b1111,
   parameter int         LINE_CNT_WIDTH = 12,
   parameter bit         EMBEDDED_PASS  = 1'b0
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      short_pkt_valid_i,
   input  logic [1:0]                short_pkt_v_channel_i,
   input  logic [5:0]                short_pkt_data_type_i,
   input  logic [15:0]               short_pkt_data_field_i,
   input  logic                      long_pkt_header_valid_i,
   input  logic [1:0]                long_pkt_v_channel_i,
   input  logic [5:0]                long_pkt_data_type_i,
   input  logic [15:0]               long_pkt_word_cnt_i,
   input  logic [31:0]               long_pkt_payload_i,
   input  logic                      long_pkt_payload_valid_i,
   input  logic [3:0]                long_pkt_payload_be_i,
   input  logic                      long_pkt_eop_i,
   input  logic                      crc_passed_i,
   input  logic                      crc_failed_i,
   output logic [31:0]               m_tdata_o,
   output logic                      m_tvalid_o,
   output logic [3:0]                m_tkeep_o,
   output logic                      m_tuser_o,
   output logic                      m_tlast_o,
   output logic [1:0]                m_tdest_o,
   output logic                      frame_done_o,
   output logic [1:0]                frame_done_vc_o,
   output logic [LINE_CNT_WIDTH-1:0] frame_lines_o,
   output logic                      sync_err_o,
   output logic [1:0]                sync_err_vc_o,
   output logic                      crc_err_o,
   output logic [1:0]                crc_err_vc_o
);
   localparam logic [5:0] DT_FS  = 6'h00;
   localparam logic [5:0] DT_FE  = 6'h01;
   localparam logic [5:0] DT_EMB = 6'h12;
   typedef enum logic {WAIT_FS, IN_FRAME} vc_state_e;
   vc_state_e                 state_q [4];
   vc_state_e                 state_d [4];
   logic [LINE_CNT_WIDTH-1:0] lines_q [4];
   logic [LINE_CNT_WIDTH-1:0] lines_d [4];
   logic [3:0]                sof_q, sof_d;
   logic                      armed_q, armed_d, fwd_q, fwd_d;
   logic [1:0]                vc_q, vc_d;
   logic [31:0]               tdata_q, tdata_d;
   logic [3:0]                tkeep_q, tkeep_d;
   logic                      tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d;
   logic [1:0]                tdest_q, tdest_d;
   logic                      done_q, done_d, sync_q, sync_d, crc_q, crc_d;
   logic [1:0]                done_vc_q, done_vc_d, sync_vc_q, sync_vc_d, crc_vc_q, crc_vc_d;
   logic [LINE_CNT_WIDTH-1:0] done_lines_q, done_lines_d;
   logic                      hdr_fwd;
   logic                      unused_inputs;
   logic [1:0]                svc, lvc;
   assign svc = short_pkt_v_channel_i;
   assign lvc = long_pkt_v_channel_i;
   assign hdr_fwd = long_pkt_data_type_i >= 6'h18 || (EMBEDDED_PASS && long_pkt_data_type_i == DT_EMB);
   assign unused_inputs = ^{crc_passed_i, short_pkt_data_field_i, long_pkt_word_cnt_i};
   // Beat forwarding first, then short packets update VC state, then the header sees that updated state
   always_comb begin
      for (int n = 0; n < 4; n++) begin
         state_d[n] = state_q[n];
         lines_d[n] = lines_q[n];
      end
      sof_d        = sof_q;
      armed_d      = armed_q;
      fwd_d        = fwd_q;
      vc_d         = vc_q;
      tdata_d      = '0;
      tkeep_d      = '0;
      tvalid_d     = 1'b0;
      tuser_d      = 1'b0;
      tlast_d      = 1'b0;
      tdest_d      = '0;
      done_d       = 1'b0;
      done_vc_d    = '0;
      done_lines_d = '0;
      sync_d       = 1'b0;
      sync_vc_d    = '0;
      crc_d        = crc_failed_i && fwd_q;
      crc_vc_d     = crc_d ? vc_q : 2'd0;
      if (armed_q && long_pkt_payload_valid_i) begin
         tvalid_d    = 1'b1;
         tdata_d     = long_pkt_payload_i;
         tkeep_d     = long_pkt_payload_be_i;
         tdest_d     = vc_q;
         tuser_d     = sof_q[vc_q];
         tlast_d     = long_pkt_eop_i;
         sof_d[vc_q] = 1'b0;
         if (long_pkt_eop_i) begin
            armed_d       = 1'b0;
            lines_d[vc_q] = &lines_q[vc_q] ? lines_q[vc_q] : lines_q[vc_q] + 1'b1;
         end
      end
      if (short_pkt_valid_i && VC_EN[svc]) begin
         if (short_pkt_data_type_i == DT_FS) begin
            sync_d       = state_q[svc] == IN_FRAME;
            sync_vc_d    = sync_d ? svc : 2'd0;
            state_d[svc] = IN_FRAME;
            sof_d[svc]   = 1'b1;
            lines_d[svc] = '0;
         end else if (short_pkt_data_type_i == DT_FE) begin
            done_d       = state_q[svc] == IN_FRAME;
            sync_d       = !done_d;
            done_vc_d    = done_d ? svc : 2'd0;
            sync_vc_d    = sync_d ? svc : 2'd0;
            done_lines_d = done_d ? lines_d[svc] : '0;
            state_d[svc] = WAIT_FS;
         end
      end
      if (long_pkt_header_valid_i && VC_EN[lvc]) begin
         armed_d = hdr_fwd && state_d[lvc] == IN_FRAME;
         fwd_d   = armed_d;
         vc_d    = armed_d ? lvc : vc_q;
         if (hdr_fwd && state_d[lvc] == WAIT_FS && !sync_d) begin
            sync_d    = 1'b1;
            sync_vc_d = lvc;
         end
      end
   end
   // State and registered outputs, all cleared by reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int n = 0; n < 4; n++) begin
            state_q[n] <= WAIT_FS;
            lines_q[n] <= '0;
         end
         sof_q        <= '0;
         armed_q      <= 1'b0;
         fwd_q        <= 1'b0;
         vc_q         <= '0;
         tdata_q      <= '0;
         tkeep_q      <= '0;
         tvalid_q     <= 1'b0;
         tuser_q      <= 1'b0;
         tlast_q      <= 1'b0;
         tdest_q      <= '0;
         done_q       <= 1'b0;
         done_vc_q    <= '0;
         done_lines_q <= '0;
         sync_q       <= 1'b0;
         sync_vc_q    <= '0;
         crc_q        <= 1'b0;
         crc_vc_q     <= '0;
      end else begin
         for (int n = 0; n < 4; n++) begin
            state_q[n] <= state_d[n];
            lines_q[n] <= lines_d[n];
         end
         sof_q        <= sof_d;
         armed_q      <= armed_d;
         fwd_q        <= fwd_d;
         vc_q         <= vc_d;
         tdata_q      <= tdata_d;
         tkeep_q      <= tkeep_d;
         tvalid_q     <= tvalid_d;
         tuser_q      <= tuser_d;
         tlast_q      <= tlast_d;
         tdest_q      <= tdest_d;
         done_q       <= done_d;
         done_vc_q    <= done_vc_d;
         done_lines_q <= done_lines_d;
         sync_q       <= sync_d;
         sync_vc_q    <= sync_vc_d;
         crc_q        <= crc_d;
         crc_vc_q     <= crc_vc_d;
      end
   end
   assign m_tdata_o       = tdata_q;
   assign m_tvalid_o      = tvalid_q;
   assign m_tkeep_o       = tkeep_q;
   assign m_tuser_o       = tuser_q;
   assign m_tlast_o       = tlast_q;
   assign m_tdest_o       = tdest_q;
   assign frame_done_o    = done_q;
   assign frame_done_vc_o = done_vc_q;
   assign frame_lines_o   = done_lines_q;
   assign sync_err_o      = sync_q;
   assign sync_err_vc_o   = sync_vc_q;
   assign crc_err_o       = crc_q;
   assign crc_err_vc_o    = crc_vc_q;
endmodule

// File: tb/tb_csi2_vc_framer.sv
// tb_csi2_vc_framer: directed checks of a default framer and one with VC_EN=0001, LINE_CNT_WIDTH=2
module tb_csi2_vc_framer;
   localparam logic [5:0] FS = 6'h00, FE = 6'h01, RAW8 = 6'h2B, EMB = 6'h12;
   logic clk = 1'b0, rst = 1'b1;
   logic sv = 1'b0, hv = 1'b0, pv = 1'b0, eop = 1'b0, crc_ok = 1'b0, crc_bad = 1'b0;
   logic [1:0] svc = '0, hvc = '0;
   logic [5:0] sdt = '0, hdt = '0;
   logic [31:0] pay = '0;
   logic [3:0] be = '0;
   logic [31:0] tdata, n_tdata;
   logic [3:0] tkeep, n_tkeep;
   logic tvalid, tuser, tlast, done, sync, crc, n_tvalid, n_tuser, n_tlast, n_done, n_sync, n_crc;
   logic [1:0] tdest, done_vc, sync_vc, crc_vc, n_tdest, n_done_vc, n_sync_vc, n_crc_vc;
   logic [11:0] lines;
   logic [1:0] n_lines;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   csi2_vc_framer dut (
      .clk_i(clk), .rst_i(rst),
      .short_pkt_valid_i(sv), .short_pkt_v_channel_i(svc), .short_pkt_data_type_i(sdt), .short_pkt_data_field_i(16'h1234),
      .long_pkt_header_valid_i(hv), .long_pkt_v_channel_i(hvc), .long_pkt_data_type_i(hdt), .long_pkt_word_cnt_i(16'd16),
      .long_pkt_payload_i(pay), .long_pkt_payload_valid_i(pv), .long_pkt_payload_be_i(be), .long_pkt_eop_i(eop),
      .crc_passed_i(crc_ok), .crc_failed_i(crc_bad),
      .m_tdata_o(tdata), .m_tvalid_o(tvalid), .m_tkeep_o(tkeep), .m_tuser_o(tuser), .m_tlast_o(tlast), .m_tdest_o(tdest),
      .frame_done_o(done), .frame_done_vc_o(done_vc), .frame_lines_o(lines),
      .sync_err_o(sync), .sync_err_vc_o(sync_vc), .crc_err_o(crc), .crc_err_vc_o(crc_vc)
   );
   csi2_vc_framer #(.VC_EN(4'b0001), .LINE_CNT_WIDTH(2)) dut_n (
      .clk_i(clk), .rst_i(rst),
      .short_pkt_valid_i(sv), .short_pkt_v_channel_i(svc), .short_pkt_data_type_i(sdt), .short_pkt_data_field_i(16'h1234),
      .long_pkt_header_valid_i(hv), .long_pkt_v_channel_i(hvc), .long_pkt_data_type_i(hdt), .long_pkt_word_cnt_i(16'd16),
      .long_pkt_payload_i(pay), .long_pkt_payload_valid_i(pv), .long_pkt_payload_be_i(be), .long_pkt_eop_i(eop),
      .crc_passed_i(crc_ok), .crc_failed_i(crc_bad),
      .m_tdata_o(n_tdata), .m_tvalid_o(n_tvalid), .m_tkeep_o(n_tkeep), .m_tuser_o(n_tuser), .m_tlast_o(n_tlast), .m_tdest_o(n_tdest),
      .frame_done_o(n_done), .frame_done_vc_o(n_done_vc), .frame_lines_o(n_lines),
      .sync_err_o(n_sync), .sync_err_vc_o(n_sync_vc), .crc_err_o(n_crc), .crc_err_vc_o(n_crc_vc)
   );
   wire [8:0]  rpt    = {sync, sync_vc, done, done_vc, crc, crc_vc};
   wire [8:0]  n_rpt  = {n_sync, n_sync_vc, n_done, n_done_vc, n_crc, n_crc_vc};
   wire [61:0] all_o  = {tdata, tvalid, tkeep, tuser, tlast, tdest, rpt, lines};
   wire [51:0] n_all  = {n_tdata, n_tvalid, n_tkeep, n_tuser, n_tlast, n_tdest, n_rpt, n_lines};
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [8:0] r(input logic s, input logic [1:0] s_vc, input logic d, input logic [1:0] d_vc, input logic c, input logic [1:0] c_vc);
      return {s, s_vc, d, d_vc, c, c_vc};
   endfunction
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic pkt(input logic s, input logic [1:0] s_vc, input logic [5:0] s_dt, input logic h, input logic [1:0] h_vc, input logic [5:0] h_dt);
      sv = s; svc = s_vc; sdt = s_dt; hv = h; hvc = h_vc; hdt = h_dt;
      step();
      sv = 1'b0; hv = 1'b0;
   endtask
   task automatic short_pkt(input logic [1:0] vc, input logic [5:0] dt);
      pkt(1'b1, vc, dt, 1'b0, 2'd0, 6'd0);
   endtask
   task automatic hdr(input logic [1:0] vc, input logic [5:0] dt);
      pkt(1'b0, 2'd0, 6'd0, 1'b1, vc, dt);
   endtask
   task automatic beats(input logic [1:0] vc, input int n, input logic last, input logic fwd, input logic first, input logic fwd_n);
      logic [31:0] d;
      logic [3:0]  k;
      logic [40:0] exp;
      for (int i = 0; i < n; i++) begin
         d = $urandom;
         k = (i == n - 1) ? 4'h3 : 4'hF;
         pay = d; be = k; pv = 1'b1; eop = last && (i == n - 1);
         step();
         pv = 1'b0; eop = 1'b0;
         exp = {1'b1, first && (i == 0), last && (i == n - 1), vc, k, d};
         chk("beat", {tvalid, tuser, tlast, tdest, tkeep, tdata}, fwd ? exp : 41'd0);
         chk("beat_n", {n_tvalid, n_tuser, n_tlast, n_tdest, n_tkeep, n_tdata}, fwd_n ? exp : 41'd0);
      end
   endtask
   task automatic crc_pulse(input logic bad);
      crc_bad = bad; crc_ok = !bad;
      step();
      crc_bad = 1'b0; crc_ok = 1'b0;
   endtask
   initial begin
      step();
      step();
      chk("reset", all_o, 0);
      chk("reset_n", n_all, 0);
      rst = 1'b0;
      short_pkt(0, FS);
      chk("fs0", rpt, 0);
      for (int l = 0; l < 3; l++) begin
         hdr(0, RAW8);
         beats(0, 4, 1'b1, 1'b1, l == 0, 1'b1);
      end
      short_pkt(0, FE);
      chk("fe0", rpt, r(0, 0, 1, 0, 0, 0));
      chk("fe0_lines", lines, 3);
      chk("fe0_n", n_rpt, r(0, 0, 1, 0, 0, 0));
      chk("fe0_lines_n", n_lines, 3);
      short_pkt(1, FS);
      short_pkt(2, FS);
      chk("fs2", rpt, 0);
      hdr(2, RAW8);
      beats(2, 2, 1'b1, 1'b1, 1'b1, 1'b0);
      hdr(1, RAW8);
      beats(1, 2, 1'b1, 1'b1, 1'b1, 1'b0);
      short_pkt(1, FE);
      chk("fe1", {rpt, lines}, {r(0, 0, 1, 1, 0, 0), 12'd1});
      chk("fe1_n", n_all, 0);
      short_pkt(2, FE);
      chk("fe2", {rpt, lines}, {r(0, 0, 1, 2, 0, 0), 12'd1});
      chk("fe2_n", n_all, 0);
      hdr(3, RAW8);
      chk("hdr3_sync", rpt, r(1, 3, 0, 0, 0, 0));
      chk("hdr3_sync_n", n_rpt, 0);
      beats(3, 2, 1'b1, 1'b0, 1'b0, 1'b0);
      short_pkt(3, FE);
      chk("fe3_sync", rpt, r(1, 3, 0, 0, 0, 0));
      pkt(1'b1, 0, FS, 1'b1, 0, RAW8);
      chk("fs_hdr_same", rpt, 0);
      beats(0, 3, 1'b1, 1'b1, 1'b1, 1'b1);
      pkt(1'b1, 0, FE, 1'b1, 1, RAW8);
      chk("done_sync", {rpt, lines}, {r(1, 1, 1, 0, 0, 0), 12'd1});
      chk("done_sync_n", {n_rpt, n_lines}, {r(0, 0, 1, 0, 0, 0), 2'd1});
      short_pkt(0, FS);
      short_pkt(0, 6'h02);
      chk("short_other", rpt, 0);
      hdr(0, EMB);
      chk("emb_noerr", rpt, 0);
      beats(0, 2, 1'b1, 1'b0, 1'b0, 1'b0);
      short_pkt(1, FS);
      chk("fs1_again", rpt, 0);
      hdr(1, RAW8);
      beats(1, 2, 1'b1, 1'b1, 1'b1, 1'b0);
      crc_pulse(1'b1);
      chk("crc_bad", rpt, r(0, 0, 0, 0, 1, 1));
      chk("crc_bad_n", n_rpt, 0);
      crc_pulse(1'b0);
      chk("crc_ok", rpt, 0);
      hdr(0, EMB);
      beats(0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
      crc_pulse(1'b1);
      chk("crc_dropped", rpt, 0);
      hdr(1, RAW8);
      beats(1, 2, 1'b0, 1'b1, 1'b0, 1'b0);
      rst = 1'b1; pay = 32'hDEADBEEF; be = 4'hF; pv = 1'b1;
      step();
      rst = 1'b0; pv = 1'b0;
      chk("mid_reset", all_o, 0);
      chk("mid_reset_n", n_all, 0);
      beats(1, 2, 1'b1, 1'b0, 1'b0, 1'b0);
      short_pkt(1, FE);
      chk("fe_after_rst", rpt, r(1, 1, 0, 0, 0, 0));
      chk("fe_after_rst_n", n_rpt, 0);
      short_pkt(0, FS);
      for (int l = 0; l < 5; l++) begin
         hdr(0, RAW8);
         beats(0, 1, 1'b1, 1'b1, l == 0, 1'b1);
      end
      short_pkt(0, FE);
      chk("fe5", {rpt, lines}, {r(0, 0, 1, 0, 0, 0), 12'd5});
      chk("fe5_sat_n", {n_rpt, n_lines}, {r(0, 0, 1, 0, 0, 0), 2'd3});
      step();
      chk("idle", all_o, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
